// File: rtl/pc_fetch_if.sv
// Bundle of instruction-memory handshake and control-unit signals around the fetch stage.
interface pc_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        instr_valid;
    logic        retire;
    logic [1:0]  branch;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fault;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, instr, op, func, instr_valid, pc, pc_plus4, fault,
        input  imem_ready, imem_rdata, retire, branch, rs_data
    );

    // Memory / control-unit side
    modport slave (
        input  imem_req, imem_addr, instr, op, func, instr_valid, pc, pc_plus4, fault,
        output imem_ready, imem_rdata, retire, branch, rs_data
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage: fetches one word per retire over a
// req/ready handshake, holds it for the control unit and steps the PC by the Branch code.
//
// state | meaning
// IDLE  | one settling cycle after reset release
// FETCH | imem_req high at pc, waiting for imem_ready
// EXEC  | instr valid, waiting for retire
// HALT  | misaligned jr target seen; frozen until reset
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_fetch_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic        jr_misaligned;

    // Next-PC candidates; all arithmetic wraps modulo 2^32
    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        br_offset     = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        jr_misaligned = (bus.branch == 2'b11) && (bus.rs_data[1:0] != 2'b00);
        case (bus.branch)
            2'b00:   next_pc = pc_plus4;
            2'b01:   next_pc = pc_plus4 + br_offset;
            2'b10:   next_pc = jump_target;
            default: next_pc = bus.rs_data;
        endcase
    end

    // Next-state logic for the fetch/exec sequencer
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (bus.imem_ready) begin
                    instr_d = bus.imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (bus.retire) begin
                    if (jr_misaligned) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end
            end
            HALT: fault_d = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any request in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        bus.imem_req    = (state_q == FETCH);
        bus.imem_addr   = pc_q;
        bus.instr_valid = (state_q == EXEC);
        bus.instr       = instr_q;
        bus.op          = instr_q[31:26];
        bus.func        = instr_q[5:0];
        bus.pc          = pc_q;
        bus.pc_plus4    = pc_plus4;
        bus.fault       = fault_q;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: hand sequences for reset/streaming/stall, then a vector
// table walking the PC through every Branch code, wrap cases and a jr fault.
module tb_pc_fetch_unit;

    logic clk;
    logic rst_n;

    pc_fetch_if bus_if ();

    pc_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] exp_pc;
        logic [31:0] word;
        logic [1:0]  br;
        logic [31:0] rs;
        int          stall;
        int          hold;
        logic [31:0] exp_next;
        logic        exp_fault;
    } vec_t;

    vec_t        vecs [15];
    logic [31:0] exp_q [$];
    int          n_cmp;
    int          n_err;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [31:0] exp_a;
        vec_t        v;
        n_cmp = 0;
        n_err = 0;

        //          exp_pc        word          br     rs            stall hold exp_next      fault
        vecs[0]  = '{32'h0000_0000, 32'h0000_0020, 2'b00, 32'h0,        0, 0, 32'h0000_0004, 1'b0};
        vecs[1]  = '{32'h0000_0004, 32'h2001_0005, 2'b00, 32'h0,        0, 0, 32'h0000_0008, 1'b0};
        vecs[2]  = '{32'h0000_0008, 32'h03E0_0008, 2'b11, 32'h0000_0100, 0, 0, 32'h0000_0100, 1'b0};
        vecs[3]  = '{32'h0000_0100, 32'h1000_FFFE, 2'b01, 32'h0,        5, 0, 32'h0000_00FC, 1'b0};
        vecs[4]  = '{32'h0000_00FC, 32'h03E0_0008, 2'b11, 32'h0000_0100, 0, 0, 32'h0000_0100, 1'b0};
        vecs[5]  = '{32'h0000_0100, 32'h1000_0003, 2'b01, 32'h0,        1, 0, 32'h0000_0110, 1'b0};
        vecs[6]  = '{32'h0000_0110, 32'h03E0_0008, 2'b11, 32'h9000_0040, 0, 0, 32'h9000_0040, 1'b0};
        vecs[7]  = '{32'h9000_0040, 32'h0C00_0010, 2'b10, 32'h0,        0, 1, 32'h9000_0040, 1'b0};
        vecs[8]  = '{32'h9000_0040, 32'h03E0_0008, 2'b11, 32'h0000_2000, 0, 0, 32'h0000_2000, 1'b0};
        vecs[9]  = '{32'h0000_2000, 32'h03E0_0008, 2'b11, 32'hFFFF_FFFC, 2, 0, 32'hFFFF_FFFC, 1'b0};
        vecs[10] = '{32'hFFFF_FFFC, 32'h0000_0020, 2'b00, 32'h0,        0, 3, 32'h0000_0000, 1'b0};
        vecs[11] = '{32'h0000_0000, 32'h1000_FFFE, 2'b01, 32'h0,        0, 0, 32'hFFFF_FFFC, 1'b0};
        vecs[12] = '{32'hFFFF_FFFC, 32'h0800_0040, 2'b10, 32'h0,        0, 0, 32'h0000_0100, 1'b0};
        vecs[13] = '{32'h0000_0100, 32'h1000_0003, 2'b00, 32'h0,        0, 0, 32'h0000_0104, 1'b0};
        vecs[14] = '{32'h0000_0104, 32'h03E0_0008, 2'b11, 32'h0000_2002, 0, 0, 32'h0000_0104, 1'b1};

        rst_n              = 1'b0;
        bus_if.imem_ready  = 1'b0;
        bus_if.imem_rdata  = 32'h0;
        bus_if.retire      = 1'b0;
        bus_if.branch      = 2'b00;
        bus_if.rs_data     = 32'h0;

        // Reset values
        step();
        chk("rst_pc", bus_if.pc, 32'h0);
        chk("rst_instr", bus_if.instr, 32'h0);
        chk("rst_valid", bus_if.instr_valid, 1'b0);
        chk("rst_req", bus_if.imem_req, 1'b0);
        chk("rst_fault", bus_if.fault, 1'b0);
        rst_n = 1'b1;
        chk("idle_req", bus_if.imem_req, 1'b0);

        // Streaming with ready and retire tied high: fetch every 2 cycles
        bus_if.imem_ready = 1'b1;
        bus_if.retire     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k % 2 == 0) begin
                chk("stream_req", bus_if.imem_req, 1'b1);
                chk("stream_addr", bus_if.imem_addr, 32'(4 * (k / 2)));
                chk("stream_valid0", bus_if.instr_valid, 1'b0);
            end else begin
                chk("stream_valid1", bus_if.instr_valid, 1'b1);
                chk("stream_req0", bus_if.imem_req, 1'b0);
                chk("stream_pc", bus_if.pc, 32'(4 * (k / 2)));
                chk("stream_pc4", bus_if.pc_plus4, 32'(4 * (k / 2) + 4));
            end
        end

        // Stall in FETCH, then async reset mid-fetch
        bus_if.imem_ready = 1'b0;
        step();
        bus_if.retire = 1'b0;
        chk("stall_addr0", bus_if.imem_addr, 32'h0000_000C);
        for (int s = 0; s < 2; s++) begin
            bus_if.imem_rdata = $urandom;
            step();
            chk("stall_req", bus_if.imem_req, 1'b1);
            chk("stall_addr", bus_if.imem_addr, 32'h0000_000C);
            chk("stall_valid", bus_if.instr_valid, 1'b0);
        end
        #2 rst_n = 1'b0;
        bus_if.imem_ready = 1'b1;
        #1;
        chk("async_rst_pc", bus_if.pc, 32'h0);
        chk("async_rst_req", bus_if.imem_req, 1'b0);
        step();
        chk("rst_late_ready", bus_if.instr_valid, 1'b0);
        bus_if.imem_ready = 1'b0;
        rst_n = 1'b1;
        chk("restart_idle_req", bus_if.imem_req, 1'b0);
        step();

        // Table-driven walk; scoreboard queue holds the next expected fetch address
        exp_q.push_back(32'h0);
        for (int i = 0; i < 15; i++) begin
            v = vecs[i];
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'(exp_q.size()), 32'd1);
                break;
            end
            exp_a = exp_q.pop_front();
            chk("fetch_req", bus_if.imem_req, 1'b1);
            chk("fetch_addr", bus_if.imem_addr, exp_a);
            for (int s = 0; s < v.stall; s++) begin
                bus_if.imem_rdata = $urandom;
                step();
                chk("wait_req", bus_if.imem_req, 1'b1);
                chk("wait_addr", bus_if.imem_addr, exp_a);
                chk("wait_valid", bus_if.instr_valid, 1'b0);
            end
            bus_if.imem_ready = 1'b1;
            bus_if.imem_rdata = v.word;
            step();
            bus_if.imem_ready = 1'b0;
            bus_if.imem_rdata = $urandom;
            chk("exec_valid", bus_if.instr_valid, 1'b1);
            chk("exec_req", bus_if.imem_req, 1'b0);
            chk("exec_instr", bus_if.instr, v.word);
            chk("exec_op", 32'(bus_if.op), 32'(v.word[31:26]));
            chk("exec_func", 32'(bus_if.func), 32'(v.word[5:0]));
            chk("exec_pc", bus_if.pc, v.exp_pc);
            chk("exec_pc4", bus_if.pc_plus4, v.exp_pc + 32'd4);
            for (int h = 0; h < v.hold; h++) begin
                step();
                chk("hold_instr", bus_if.instr, v.word);
                chk("hold_pc", bus_if.pc, v.exp_pc);
                chk("hold_valid", bus_if.instr_valid, 1'b1);
            end
            bus_if.retire  = 1'b1;
            bus_if.branch  = v.br;
            bus_if.rs_data = v.rs;
            if (!v.exp_fault) exp_q.push_back(v.exp_next);
            step();
            bus_if.retire  = 1'b0;
            bus_if.branch  = 2'b00;
            bus_if.rs_data = $urandom;
            chk("retire_fault", bus_if.fault, v.exp_fault);
            chk("retire_valid", bus_if.instr_valid, 1'b0);
            if (v.exp_fault) begin
                chk("halt_req", bus_if.imem_req, 1'b0);
                chk("halt_pc", bus_if.pc, v.exp_next);
            end
        end

        // HALT ignores retire and imem_ready
        bus_if.retire     = 1'b1;
        bus_if.imem_ready = 1'b1;
        bus_if.branch     = 2'b00;
        for (int s = 0; s < 4; s++) begin
            step();
            chk("halt_hold_fault", bus_if.fault, 1'b1);
            chk("halt_hold_req", bus_if.imem_req, 1'b0);
            chk("halt_hold_valid", bus_if.instr_valid, 1'b0);
            chk("halt_hold_pc", bus_if.pc, 32'h0000_0104);
        end
        bus_if.retire     = 1'b0;
        bus_if.imem_ready = 1'b0;

        // Reset is the only exit from HALT
        #2 rst_n = 1'b0;
        #1;
        chk("halt_rst_fault", bus_if.fault, 1'b0);
        chk("halt_rst_pc", bus_if.pc, 32'h0);
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_req", bus_if.imem_req, 1'b1);
        chk("post_rst_addr", bus_if.imem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
